// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single SDRAM controller port between the ROM/VHD loader stream and the CPU bus.
// Optional loader write readback verification is enabled with the ARB_READBACK_CHECK_EN macro.
module sdram_port_arbiter #(
  parameter int AW           = 23,
  parameter int DW           = 8,
  parameter int LFIFO_DEPTH  = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ld_active,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_busy,
  output logic          ld_overflow,
  input  logic          cpu_rd_n,
  input  logic          cpu_wr_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_rdy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic          mem_ready,
  output logic          chk_err
);

  localparam int PW = $clog2(LFIFO_DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

`ifdef ARB_READBACK_CHECK_EN
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ISSUE_RB, WAIT_RB
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE
  } state_t;
`endif

  state_t        state_q, state_d;
  logic          grant_ld_q, grant_ld_d;
  logic          op_wr_q, op_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_rd_q, mem_rd_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic          cpu_rdy_q, cpu_rdy_d;
  logic          ld_overflow_q, ld_overflow_d;
  logic          ld_active_q, ld_active_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
`ifdef ARB_READBACK_CHECK_EN
  logic          chk_err_q, chk_err_d;
  logic          seen_busy_q, seen_busy_d;
  logic          rb_done;
`endif

  logic [AW-1:0] fifo_addr_q [LFIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [LFIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic fifo_push;
  logic fifo_pop;
  logic ld_rise;
  logic tmo_last;
  logic op_done;

  // FIFO bookkeeping: the extra pointer bit separates full from empty
  always_comb begin
    fifo_empty    = (wptr_q == rptr_q);
    fifo_full     = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                    (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
    fifo_pop      = (state_q == ISSUE) && grant_ld_q;
    fifo_push     = ld_wr && (!fifo_full || fifo_pop);
    ld_rise       = ld_active && !ld_active_q;
    ld_active_d   = ld_active;
    wptr_d        = fifo_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d        = fifo_pop  ? rptr_q + PW'(1) : rptr_q;
    ld_overflow_d = ld_rise ? 1'b0 : ld_overflow_q;
    if (ld_wr && fifo_full && !fifo_pop) begin
      ld_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (fifo_push) begin
      fifo_addr_q[wptr_q[PW-2:0]] <= ld_addr;
      fifo_data_q[wptr_q[PW-2:0]] <= ld_data;
    end
  end

  always_comb begin
    tmo_last   = (tmo_q == TW'(BUSY_TIMEOUT - 1));
    state_d    = state_q;
    grant_ld_d = grant_ld_q;
    op_wr_d    = op_wr_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    mem_rd_d   = 1'b0;
    cpu_dout_d = cpu_dout_q;
    cpu_rdy_d  = cpu_rdy_q && !(cpu_rd_n && cpu_wr_n);
    tmo_d      = tmo_q;
    op_done    = 1'b0;
`ifdef ARB_READBACK_CHECK_EN
    chk_err_d   = ld_rise ? 1'b0 : chk_err_q;
    seen_busy_d = seen_busy_q;
    rb_done     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (mem_ready) begin
          if (!fifo_empty) begin
            grant_ld_d = 1'b1;
            op_wr_d    = 1'b1;
            mem_addr_d = fifo_addr_q[rptr_q[PW-2:0]];
            mem_din_d  = fifo_data_q[rptr_q[PW-2:0]];
            state_d    = ISSUE;
          end else if (!ld_active && !cpu_rdy_q && (!cpu_rd_n || !cpu_wr_n)) begin
            // Both strobes low resolves to a write
            grant_ld_d = 1'b0;
            op_wr_d    = !cpu_wr_n;
            mem_addr_d = cpu_addr;
            mem_din_d  = cpu_din;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_we_d = op_wr_q;
        mem_rd_d = !op_wr_q;
        tmo_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A controller that never drops ready is assumed to have finished
        if (!mem_ready) begin
          state_d = WAIT_DONE;
        end else if (tmo_last) begin
          op_done = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (mem_ready) begin
          op_done = 1'b1;
        end
      end
`ifdef ARB_READBACK_CHECK_EN
      ISSUE_RB: begin
        mem_rd_d    = 1'b1;
        tmo_d       = '0;
        seen_busy_d = 1'b0;
        state_d     = WAIT_RB;
      end
      WAIT_RB: begin
        if (!seen_busy_q) begin
          if (!mem_ready) begin
            seen_busy_d = 1'b1;
          end else if (tmo_last) begin
            rb_done = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else if (mem_ready) begin
          rb_done = 1'b1;
        end
        if (rb_done) begin
          if (mem_dout != mem_din_q) begin
            chk_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (op_done) begin
      state_d = IDLE;
      if (!grant_ld_q) begin
        cpu_rdy_d = 1'b1;
        if (!op_wr_q) begin
          cpu_dout_d = mem_dout;
        end
      end
`ifdef ARB_READBACK_CHECK_EN
      else begin
        // Loader writes are verified before anyone else gets the port
        state_d = ISSUE_RB;
      end
`endif
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_ld_q    <= 1'b0;
      op_wr_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      cpu_dout_q    <= '0;
      cpu_rdy_q     <= 1'b0;
      ld_overflow_q <= 1'b0;
      ld_active_q   <= 1'b0;
      tmo_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
`ifdef ARB_READBACK_CHECK_EN
      chk_err_q     <= 1'b0;
      seen_busy_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_ld_q    <= grant_ld_d;
      op_wr_q       <= op_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_we_q      <= mem_we_d;
      mem_rd_q      <= mem_rd_d;
      cpu_dout_q    <= cpu_dout_d;
      cpu_rdy_q     <= cpu_rdy_d;
      ld_overflow_q <= ld_overflow_d;
      ld_active_q   <= ld_active_d;
      tmo_q         <= tmo_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
`ifdef ARB_READBACK_CHECK_EN
      chk_err_q     <= chk_err_d;
      seen_busy_q   <= seen_busy_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign mem_rd      = mem_rd_q;
  assign cpu_dout    = cpu_dout_q;
  assign cpu_rdy     = cpu_rdy_q;
  assign ld_overflow = ld_overflow_q;
  assign ld_busy     = !fifo_empty || ((state_q != IDLE) && grant_ld_q);
`ifdef ARB_READBACK_CHECK_EN
  assign chk_err     = chk_err_q;
`else
  assign chk_err     = 1'b0;
`endif

endmodule
